wb_sdram_arb: RTL and testbench

- Round-robin Wishbone arbiter that shares the single WB slave port of the SDRAM controller among NUM_MASTERS Wishbone masters (CPU, DMA, video, etc.).
- Ownership is held for a whole cycle (`cyc` high), so incremental bursts (`cti` = 010 ... 111) reach the SDRAM controller uninterrupted.
- An ack watchdog aborts a stalled tenure with a Wishbone error to the owning master, so the other masters are not locked out.

---
 rtl/wb_arb_pkg.sv | 27 ++
 rtl/rr_pick.sv | 34 +++
 rtl/wb_sdram_arb.sv | 155 +++++++++++++++
 tb/tb_wb_sdram_arb.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_arb_pkg.sv
// Shared types and constants for the Wishbone SDRAM arbiter.
//   arb_state_e : arbiter FSM states
//   WB_*        : Wishbone data / select / cycle-type widths
//   CTI_*       : cycle-type identifier encodings
//   cnt_width() : watchdog counter width (at least one bit, even when disabled)
package wb_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN   = 2'd1,
        ABORT = 2'd2
    } arb_state_e;

    localparam int WB_DW    = 32;
    localparam int WB_SW    = 4;
    localparam int WB_CTI_W = 3;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_EOB     = 3'b111;

    // A disabled watchdog (timeout 0) still needs a legal 1-bit counter.
    function automatic int cnt_width(input int timeout);
        return (timeout > 0) ? $clog2(timeout + 1) : 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker.
//   req   : request vector, one bit per requester
//   last  : index of the most recent winner (searched from last+1 upwards)
//   idx   : winning index, valid only when valid = 1
//   valid : at least one request present
// The request vector is doubled and shifted right by last+1, so the lowest set
// bit of the low half is the first requester after last in circular order.
module rr_pick #(
    parameter int N     = 4,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] last,
    output logic [IDX_W-1:0] idx,
    output logic             valid
);

    logic [N-1:0] rot_s;
    int           base_s;

    // Rotate the requests and priority-encode the lowest set bit.
    always_comb begin
        base_s = int'(last) + 1;
        rot_s  = N'({req, req} >> base_s);
        idx    = '0;
        valid  = 1'b0;
        // Descending scan: the lowest set bit is written last and wins.
        for (int i = N - 1; i >= 0; i--) begin
            valid = valid | rot_s[i];
            idx   = rot_s[i] ? IDX_W'((base_s + i) % N) : idx;
        end
    end

endmodule

// File: rtl/wb_sdram_arb.sv
// Round-robin Wishbone arbiter in front of the SDRAM controller slave port.
//   wb_clk_i / wb_rst_n_i : clock, asynchronous active-low reset
//   m_wb_*                : NUM_MASTERS packed master ports (master k in slice k)
//   s_wb_*                : single slave port to the SDRAM controller
//   grant_o / busy_o      : current owner index and "not idle" debug status
// An owner keeps the slave for its whole cyc so bursts are never split. An ack
// watchdog turns a stalled tenure into a one-cycle err pulse to the owner.
module wb_sdram_arb
    import wb_arb_pkg::*;
#(
    parameter int NUM_MASTERS = 4,
    parameter int ADR_W       = 24,
    parameter int TIMEOUT     = 1023,
    parameter int CNT_W       = cnt_width(TIMEOUT)
) (
    input  logic                            wb_clk_i,
    input  logic                            wb_rst_n_i,
    input  logic [NUM_MASTERS-1:0]          m_wb_cyc_i,
    input  logic [NUM_MASTERS-1:0]          m_wb_stb_i,
    input  logic [NUM_MASTERS-1:0]          m_wb_we_i,
    input  logic [NUM_MASTERS*4-1:0]        m_wb_sel_i,
    input  logic [NUM_MASTERS*ADR_W-1:0]    m_wb_adr_i,
    input  logic [NUM_MASTERS*3-1:0]        m_wb_cti_i,
    input  logic [NUM_MASTERS*32-1:0]       m_wb_dat_i,
    output logic [31:0]                     m_wb_dat_o,
    output logic [NUM_MASTERS-1:0]          m_wb_ack_o,
    output logic [NUM_MASTERS-1:0]          m_wb_err_o,
    output logic                            s_wb_cyc_o,
    output logic                            s_wb_stb_o,
    output logic                            s_wb_we_o,
    output logic [3:0]                      s_wb_sel_o,
    output logic [ADR_W-1:0]                s_wb_adr_o,
    output logic [2:0]                      s_wb_cti_o,
    output logic [31:0]                     s_wb_dat_o,
    input  logic [31:0]                     s_wb_dat_i,
    input  logic                            s_wb_ack_i,
    output logic [$clog2(NUM_MASTERS)-1:0]  grant_o,
    output logic                            busy_o
);

    localparam int GW      = $clog2(NUM_MASTERS);
    localparam bit WDOG_EN = (TIMEOUT > 0);

    arb_state_e             state_r;
    logic [GW-1:0]          grant_r;
    logic [GW-1:0]          last_r;
    logic [CNT_W-1:0]       wdog_r;
    logic [NUM_MASTERS-1:0] err_r;

    logic [GW-1:0]          pick_idx_s;
    logic                   pick_valid_s;
    logic                   stall_s;
    logic                   wdog_hit_s;
    int                     gi_s;

    rr_pick #(
        .N     (NUM_MASTERS),
        .IDX_W (GW)
    ) u_pick (
        .req   (m_wb_cyc_i),
        .last  (last_r),
        .idx   (pick_idx_s),
        .valid (pick_valid_s)
    );

    // Slave-side mux and ack routing; everything is quiet outside OWN.
    always_comb begin
        gi_s       = int'(grant_r);
        s_wb_cyc_o = 1'b0;
        s_wb_stb_o = 1'b0;
        s_wb_we_o  = 1'b0;
        s_wb_sel_o = 4'h0;
        s_wb_adr_o = '0;
        s_wb_cti_o = 3'b000;
        s_wb_dat_o = 32'h0;
        m_wb_ack_o = '0;
        case (state_r)
            OWN: begin
                s_wb_cyc_o          = m_wb_cyc_i[grant_r];
                s_wb_stb_o          = m_wb_stb_i[grant_r];
                s_wb_we_o           = m_wb_we_i[grant_r];
                s_wb_sel_o          = m_wb_sel_i[gi_s*WB_SW +: WB_SW];
                s_wb_adr_o          = m_wb_adr_i[gi_s*ADR_W +: ADR_W];
                s_wb_cti_o          = m_wb_cti_i[gi_s*WB_CTI_W +: WB_CTI_W];
                s_wb_dat_o          = m_wb_dat_i[gi_s*WB_DW +: WB_DW];
                m_wb_ack_o[grant_r] = s_wb_ack_i;
            end
            default: begin
                s_wb_cyc_o = 1'b0;
            end
        endcase
    end

    // Watchdog qualifiers: a stall is a strobe without ack; an ack always wins.
    always_comb begin
        stall_s    = s_wb_stb_o & ~s_wb_ack_i;
        wdog_hit_s = WDOG_EN & stall_s & (wdog_r == CNT_W'(TIMEOUT - 1));
    end

    // Arbiter FSM with watchdog counter and one-cycle error pulse.
    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            state_r <= IDLE;
            grant_r <= '0;
            last_r  <= GW'(NUM_MASTERS - 1);
            wdog_r  <= '0;
            err_r   <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    err_r  <= '0;
                    wdog_r <= '0;
                    if (pick_valid_s) begin
                        grant_r <= pick_idx_s;
                        state_r <= OWN;
                    end
                end
                OWN: begin
                    err_r <= '0;
                    // Owner ending its cycle takes priority over a timeout.
                    if (!m_wb_cyc_i[grant_r]) begin
                        state_r <= IDLE;
                        last_r  <= grant_r;
                        wdog_r  <= '0;
                    end else if (wdog_hit_s) begin
                        state_r <= ABORT;
                        err_r   <= NUM_MASTERS'(1) << grant_r;
                        wdog_r  <= '0;
                    end else if (stall_s) begin
                        wdog_r  <= wdog_r + CNT_W'(1);
                    end else begin
                        wdog_r  <= '0;
                    end
                end
                ABORT: begin
                    err_r <= '0;
                    if (!m_wb_cyc_i[grant_r]) begin
                        state_r <= IDLE;
                        last_r  <= grant_r;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    err_r   <= '0;
                end
            endcase
        end
    end

    assign m_wb_dat_o = s_wb_dat_i;
    assign m_wb_err_o = err_r;
    assign grant_o    = grant_r;
    assign busy_o     = (state_r != IDLE);

endmodule

// File: tb/tb_wb_sdram_arb.sv
// Randomized bench for wb_sdram_arb. Masters push every beat they present into
// a per-master queue; a monitor follows tenures with a round-robin model and
// pops/compares whenever the slave completes a beat.
module tb_wb_sdram_arb;
    import wb_arb_pkg::*;

    localparam int N  = 4;
    localparam int AW = 24;
    localparam int TO = 16;

    logic                clk;
    logic                rst_n;
    logic [N-1:0]        m_cyc, m_stb, m_we;
    logic [N*4-1:0]      m_sel;
    logic [N*AW-1:0]     m_adr;
    logic [N*3-1:0]      m_cti;
    logic [N*32-1:0]     m_dat;
    logic [31:0]         m_dat_o;
    logic [N-1:0]        m_ack, m_err;
    logic                s_cyc, s_stb, s_we;
    logic [3:0]          s_sel;
    logic [AW-1:0]       s_adr;
    logic [2:0]          s_cti;
    logic [31:0]         s_dat_o, s_dat_i;
    logic                s_ack;
    logic [1:0]          grant;
    logic                busy;

    wb_sdram_arb #(.NUM_MASTERS(N), .ADR_W(AW), .TIMEOUT(TO)) dut (
        .wb_clk_i(clk), .wb_rst_n_i(rst_n),
        .m_wb_cyc_i(m_cyc), .m_wb_stb_i(m_stb), .m_wb_we_i(m_we),
        .m_wb_sel_i(m_sel), .m_wb_adr_i(m_adr), .m_wb_cti_i(m_cti),
        .m_wb_dat_i(m_dat), .m_wb_dat_o(m_dat_o), .m_wb_ack_o(m_ack),
        .m_wb_err_o(m_err), .s_wb_cyc_o(s_cyc), .s_wb_stb_o(s_stb),
        .s_wb_we_o(s_we), .s_wb_sel_o(s_sel), .s_wb_adr_o(s_adr),
        .s_wb_cti_o(s_cti), .s_wb_dat_o(s_dat_o), .s_wb_dat_i(s_dat_i),
        .s_wb_ack_i(s_ack), .grant_o(grant), .busy_o(busy)
    );

    typedef struct {
        logic        we;
        logic [3:0]  sel;
        logic [AW-1:0] adr;
        logic [2:0]  cti;
        logic [31:0] dat;
    } beat_t;

    beat_t       exp_q[N][$];
    int          gq[$];
    int          checks = 0;
    int          errors = 0;
    logic [7:0]  hold_mask = 8'h00;
    logic [31:0] slv_rdata = 32'h0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk_eq(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic int rr_next(input logic [N-1:0] req, input int last);
        for (int d = 1; d <= N; d++) begin
            if (req[(last + d) % N]) return (last + d) % N;
        end
        return -1;
    endfunction

    // Slave: random acks unless the beat's master (address top bits) is held.
    task automatic slv_loop();
        s_ack   = 1'b0;
        s_dat_i = 32'h0;
        forever begin
            @(negedge clk); #1;
            if (s_cyc && s_stb && !hold_mask[s_adr[AW-1 -: 3]] && $urandom_range(2, 0) != 0) begin
                s_ack     = 1'b1;
                slv_rdata = $urandom;
                s_dat_i   = slv_rdata;
            end else begin
                s_ack   = 1'b0;
                s_dat_i = $urandom;
            end
        end
    endtask

    // Monitor with a tenure-level round-robin reference model.
    task automatic mon_loop();
        int owner = -1, nxt = -1, last = N - 1, stall = 0;
        int waits[N];
        bit aborted = 0, abort_next = 0, err_first;
        logic [N-1:0] oh;
        beat_t e;
        foreach (waits[i]) waits[i] = 0;
        forever begin
            @(negedge clk); #3;
            if (!rst_n) begin
                chk_eq("reset_slave_cyc", {s_cyc, s_stb}, 2'b00);
                chk_eq("reset_ack", m_ack, '0);
                chk_eq("reset_err", m_err, '0);
                chk_eq("reset_busy_grant", {busy, grant}, 3'b000);
                owner = -1; nxt = -1; last = N - 1; stall = 0;
                aborted = 0; abort_next = 0;
                foreach (waits[i]) waits[i] = 0;
            end else begin
                err_first = 0;
                if (nxt >= 0) begin
                    owner = nxt; nxt = -1; aborted = 0; stall = 0;
                    gq.push_back(owner);
                end
                if (abort_next) begin
                    aborted = 1; abort_next = 0; err_first = 1;
                    if (exp_q[owner].size() > 0) void'(exp_q[owner].pop_front());
                end
                oh = (owner >= 0) ? (N'(1) << owner) : '0;
                chk_eq("err_vector", m_err, err_first ? oh : '0);
                if (owner >= 0) begin
                    chk_eq("busy_own", busy, 1'b1);
                    chk_eq("grant_own", grant, owner);
                    chk_eq("slave_cyc_stb", {s_cyc, s_stb},
                           aborted ? 2'b00 : {m_cyc[owner], m_stb[owner]});
                    if (!aborted && m_cyc[owner] && m_stb[owner] && s_ack) begin
                        chk_eq("ack_route", m_ack, oh);
                        chk_eq("rd_data", m_dat_o, slv_rdata);
                        if (exp_q[owner].size() == 0) begin
                            chk_eq("beat_queue_empty", 1'b1, 1'b0);
                        end else begin
                            e = exp_q[owner].pop_front();
                            chk_eq("beat_fields", {s_we, s_sel, s_adr, s_cti, s_dat_o},
                                   {e.we, e.sel, e.adr, e.cti, e.dat});
                        end
                    end else begin
                        chk_eq("no_ack", m_ack, '0);
                    end
                    if (!aborted && m_cyc[owner]) begin
                        stall = (m_stb[owner] && !s_ack) ? stall + 1 : 0;
                        if (stall == TO) abort_next = 1;
                    end
                    if (!m_cyc[owner]) begin
                        last = owner; owner = -1; stall = 0; abort_next = 0;
                    end
                end else begin
                    chk_eq("idle_busy_cyc", {busy, s_cyc}, 2'b00);
                    if (m_cyc != '0) begin
                        nxt = rr_next(m_cyc, last);
                        for (int j = 0; j < N; j++) begin
                            if (j == nxt || !m_cyc[j]) waits[j] = 0;
                            else waits[j]++;
                            if (waits[j] > N - 1) chk_eq("starvation", waits[j], N - 1);
                        end
                    end
                end
            end
        end
    endtask

    // One master tenure of nb beats; fixed=1 issues the directed classic write.
    task automatic run_tenure(input int k, input int nb, input bit burst, input bit fixed,
                              output int acks, output bit got_err);
        beat_t bt;
        int    w;
        bit    done;
        acks = 0; got_err = 0;
        for (int b = 0; b < nb && !got_err; b++) begin
            bt.we  = 1'($urandom_range(1, 0));
            bt.sel = 4'($urandom_range(15, 1));
            bt.adr = {3'(k), 21'($urandom)};
            bt.cti = !burst ? CTI_CLASSIC : (b == nb - 1) ? CTI_EOB : CTI_INCR;
            bt.dat = $urandom;
            if (fixed) begin
                bt.we = 1'b1; bt.sel = 4'hF; bt.adr = 24'h000100;
                bt.cti = CTI_CLASSIC; bt.dat = 32'hDEADBEEF;
            end
            @(posedge clk); #1;
            m_cyc[k] = 1'b1; m_stb[k] = 1'b1; m_we[k] = bt.we;
            m_sel[k*4 +: 4] = bt.sel; m_adr[k*AW +: AW] = bt.adr;
            m_cti[k*3 +: 3] = bt.cti; m_dat[k*32 +: 32] = bt.dat;
            exp_q[k].push_back(bt);
            w = 0; done = 0;
            while (!done) begin
                @(negedge clk); #2;
                if (m_ack[k]) begin
                    acks++; done = 1;
                end else if (m_err[k]) begin
                    got_err = 1; done = 1;
                end else if (w >= 300) begin
                    checks++; errors++;
                    $display("FAIL beat_wait master %0d: no ack/err after %0d cycles, required ack", k, w);
                    got_err = 1; done = 1;
                end
                w++;
            end
        end
        @(posedge clk); #1;
        m_cyc[k] = 1'b0; m_stb[k] = 1'b0;
    endtask

    task automatic fair_loop(input int k);
        int a; bit e;
        for (int t = 0; t < 10; t++)
            run_tenure(k, $urandom_range(3, 1), 1'($urandom_range(1, 0)), 1'b0, a, e);
    endtask

    task automatic do_reset();
        @(posedge clk); #1; rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1; rst_n = 1'b1;
        gq.delete();
    endtask

    initial begin
        int  a0, a1, a2, a3;
        bit  e0, e1, e2, e3;
        rst_n = 1'b0;
        m_cyc = '0; m_stb = '0; m_we = '0; m_sel = '0;
        m_adr = '0; m_cti = '0; m_dat = '0;
        fork
            slv_loop();
            mon_loop();
        join_none

        // Single master 0 classic write.
        do_reset();
        run_tenure(0, 1, 1'b0, 1'b1, a0, e0);
        repeat (3) @(posedge clk);
        chk_eq("p1_acks", a0, 1);
        chk_eq("p1_order", {gq.size(), gq[0]}, {32'd1, 32'd0});

        // Masters 1 and 3 together from reset.
        do_reset();
        fork
            run_tenure(1, 3, 1'b0, 1'b0, a1, e1);
            run_tenure(3, 2, 1'b0, 1'b0, a3, e3);
        join
        repeat (3) @(posedge clk);
        chk_eq("p2_order", {gq.size(), gq[0], gq[1]}, {32'd2, 32'd1, 32'd3});

        // Master 2 burst, master 0 asks mid-burst.
        fork
            run_tenure(2, 8, 1'b1, 1'b0, a2, e2);
            begin repeat (4) @(posedge clk); run_tenure(0, 2, 1'b0, 1'b0, a0, e0); end
        join
        repeat (3) @(posedge clk);
        chk_eq("p3_burst_acks", a2, 8);
        chk_eq("p3_order", {gq[2], gq[3]}, {32'd2, 32'd0});

        // Watchdog: master 1 never acked, master 2 waiting.
        do_reset();
        hold_mask = 8'h02;
        fork
            run_tenure(1, 2, 1'b0, 1'b0, a1, e1);
            begin repeat (3) @(posedge clk); run_tenure(2, 2, 1'b0, 1'b0, a2, e2); end
        join
        hold_mask = 8'h00;
        repeat (3) @(posedge clk);
        chk_eq("p4_err_acks", {e1, a1[7:0]}, {1'b1, 8'd0});
        chk_eq("p4_m2_served", {e2, a2[7:0]}, {1'b0, 8'd2});
        chk_eq("p4_order", {gq[0], gq[1]}, {32'd1, 32'd2});

        // Reset in the middle of master 0's burst.
        do_reset();
        fork
            run_tenure(0, 8, 1'b1, 1'b0, a0, e0);
            begin repeat (3) @(posedge clk); run_tenure(2, 1, 1'b0, 1'b0, a2, e2); end
            begin
                repeat (6) @(posedge clk);
                #1;
                chk_eq("p5_pre_reset_cyc", s_cyc, 1'b1);
                rst_n = 1'b0;
                #1;
                chk_eq("p5_reset_cyc_drop", s_cyc, 1'b0);
                chk_eq("p5_reset_ack_err", {m_ack, m_err}, '0);
                repeat (2) @(posedge clk);
                #1; rst_n = 1'b1;
                gq.delete();
            end
        join
        repeat (3) @(posedge clk);
        chk_eq("p5_first_after_reset", gq[0], 0);

        // All four masters hammering: strict 0,1,2,3 rotation.
        do_reset();
        fork
            fair_loop(0);
            fair_loop(1);
            fair_loop(2);
            fair_loop(3);
        join
        repeat (3) @(posedge clk);
        chk_eq("p6_tenures", gq.size(), 40);
        for (int i = 0; i < gq.size(); i++) chk_eq("p6_order", gq[i], i % N);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
